pipe_trace_buffer: RTL

- Parametrised on-chip trace capture for the pipeline processor.
- Replaces ad-hoc bench-level probing of register-file and data-memory taps (read addresses/data, DM address/read data) with a synthesizable multi-channel circular buffer.
- Records probe samples continuously once armed, freezes a programmable number of samples after a trigger, then streams the window out oldest-first over a valid/ready port.

---
 rtl/pipe_trace_buffer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer -- multi-channel circular trace capture buffer.
//
// Records packed probe samples continuously once armed, keeps capturing a
// programmable number of samples after a trigger, then streams the captured
// window out oldest-first over a valid/ready port.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   arm          start capture (IDLE only)
//   abort        return to IDLE from any state, clears pointers and counts
//   trig         trigger event (ARMED only)
//   post_count   samples to capture after the trigger sample (clamped to DEPTH)
//   probe        packed sample, channel k = probe[k*DATA_W +: DATA_W]
//   probe_valid  probe carries a sample this cycle
//   rd_valid     rd_data holds a buffered sample
//   rd_ready     consumer accepts rd_data
//   rd_data      oldest unread sample (zero when rd_valid is low)
//   rd_last      rd_data is the final sample of the window
//   state        0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   fill         valid entries held, saturates at DEPTH
//   wrapped      oldest entry has been overwritten at least once since arm
module pipe_trace_buffer #(
   parameter int DATA_W   = 32,
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 16,
   parameter int CW       = $clog2(DEPTH + 1)
) (
   input  logic                       CLK,
   input  logic                       rst,
   input  logic                       arm,
   input  logic                       abort,
   input  logic                       trig,
   input  logic [CW-1:0]              post_count,
   input  logic [CHANNELS*DATA_W-1:0] probe,
   input  logic                       probe_valid,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [CHANNELS*DATA_W-1:0] rd_data,
   output logic                       rd_last,
   output logic [2:0]                 state,
   output logic [CW-1:0]              fill,
   output logic                       wrapped
);

   localparam int SW = CHANNELS * DATA_W;
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_POST  = 3'd2,
      S_DONE  = 3'd3
   } state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    fill_q, fill_d;
   logic             wrapped_q, wrapped_d;
   logic [CW-1:0]    remaining_q, remaining_d;
   logic [CW-1:0]    unread_q, unread_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_last_q, rd_last_d;
   logic             we_s;
   logic [CW-1:0]    post_clamp_s;
   logic [SW-1:0]    ram_q [DEPTH];

   // Clamp the requested post-trigger length to the buffer depth.
   always_comb begin
      if (post_count > DEPTH_C) begin
         post_clamp_s = DEPTH_C;
      end else begin
         post_clamp_s = post_count;
      end
   end

   // Next-state logic for the capture / readout controller.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_d      = fill_q;
      wrapped_d   = wrapped_q;
      remaining_d = remaining_q;
      unread_d    = unread_q;
      we_s        = 1'b0;

      if (abort) begin
         state_d     = S_IDLE;
         wr_ptr_d    = {AW{1'b0}};
         rd_ptr_d    = {AW{1'b0}};
         fill_d      = {CW{1'b0}};
         wrapped_d   = 1'b0;
         remaining_d = {CW{1'b0}};
         unread_d    = {CW{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  state_d   = S_ARMED;
                  wr_ptr_d  = {AW{1'b0}};
                  fill_d    = {CW{1'b0}};
                  wrapped_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ARMED, S_POST: begin
               if (probe_valid) begin
                  we_s     = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  if (fill_q == DEPTH_C) begin
                     wrapped_d = 1'b1;
                  end else begin
                     fill_d = fill_q + CW'(1);
                  end
               end else begin
                  we_s = 1'b0;
               end

               if (state_q == S_ARMED) begin
                  if (trig) begin
                     if (post_clamp_s == {CW{1'b0}}) begin
                        state_d = S_DONE;
                     end else begin
                        state_d     = S_POST;
                        remaining_d = post_clamp_s;
                     end
                  end else begin
                     state_d = S_ARMED;
                  end
               end else begin
                  // Only valid samples consume the post-trigger budget.
                  if (probe_valid) begin
                     remaining_d = remaining_q - CW'(1);
                     if (remaining_q == CW'(1)) begin
                        state_d = S_DONE;
                     end else begin
                        state_d = S_POST;
                     end
                  end else begin
                     state_d = S_POST;
                  end
               end
            end
            S_DONE: begin
               if (unread_q == {CW{1'b0}}) begin
                  state_d = S_IDLE;
                  fill_d  = {CW{1'b0}};
               end else if (rd_valid_q && rd_ready) begin
                  rd_ptr_d = rd_ptr_q + AW'(1);
                  unread_d = unread_q - CW'(1);
                  if (unread_q == CW'(1)) begin
                     state_d = S_IDLE;
                     fill_d  = {CW{1'b0}};
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // On DONE entry the oldest entry sits fill slots behind the write
      // pointer; a full buffer truncates fill to 0, i.e. the write pointer.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];
         unread_d = fill_d;
      end else begin
         rd_ptr_d = rd_ptr_d;
         unread_d = unread_d;
      end

      rd_valid_d = (state_d == S_DONE) && (unread_d != {CW{1'b0}});
      rd_last_d  = (state_d == S_DONE) && (unread_d == CW'(1));
   end

   // Controller registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         fill_q      <= {CW{1'b0}};
         wrapped_q   <= 1'b0;
         remaining_q <= {CW{1'b0}};
         unread_q    <= {CW{1'b0}};
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         wrapped_q   <= wrapped_d;
         remaining_q <= remaining_d;
         unread_q    <= unread_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
      end
   end

   // Trace RAM write port; contents are deliberately not reset.
   always_ff @(posedge CLK) begin
      if (!rst && we_s) begin
         ram_q[wr_ptr_q] <= probe;
      end
   end

   assign rd_data = rd_valid_q ? ram_q[rd_ptr_q] : {SW{1'b0}};
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign state    = state_q;
   assign fill     = fill_q;
   assign wrapped  = wrapped_q;

endmodule
